// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared definitions for the instruction fetch unit.
//   * pc_src encodings for the next-PC selector
//   * fetch FSM state enum
//   * default RESET_PC and TIMEOUT_CYC values
//   * IR field bit positions (opcode / rs / rt / imediato)
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 15;

    // Next-PC source select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // pc + 4
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;  // branch_target
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;  // jump_target
    localparam logic [1:0] PC_SRC_REG    = 2'b11;  // reg_target

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_t;

    // IR field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/fetch_unit_ir_reg.sv
// ir_reg -- 32-bit instruction register with load enable and asynchronous
// active-low clear, split into its decode fields.
// Ports:
//   clk      in   clock
//   clr_n    in   asynchronous active-low clear (IR <= 0)
//   load     in   capture d on the rising edge
//   d        in   32-bit instruction word
//   opcode   out  IR[31:26]
//   rs       out  IR[25:21]
//   rt       out  IR[20:16]
//   imediato out  IR[15:0]
module ir_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clr_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imediato
);

    logic [31:0] ir_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ir_q <= 32'h0;
        end else if (load) begin
            ir_q <= d;
        end
    end

    assign opcode   = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign rs       = ir_q[RS_MSB:RS_LSB];
    assign rt       = ir_q[RT_MSB:RT_LSB];
    assign imediato = ir_q[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch: PC register, next-PC select, a three-state
// fetch FSM (IDLE/REQ/DONE) and the instruction register.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a fetch after
// TIMEOUT_CYC cycles without mem_ready (fetch_err pulses, pc/IR unchanged).
// Without it REQ waits indefinitely and fetch_err is tied low.
//
// Memory handshake: mem_rd is high exactly while in REQ, with mem_addr = pc
// held stable. The read completes on the first rising edge where mem_rd and
// mem_ready are both high; mem_rdata is captured on that edge. mem_ready
// outside REQ (e.g. a late answer to a request aborted by reset) is ignored.
//
// Ports:
//   clk, reset (async, active-low)
//   start, pc_write, pc_src[1:0], branch_target, jump_target, reg_target
//   mem_rd, mem_addr[31:0], mem_ready, mem_rdata[31:0]
//   opcode[5:0], rs[4:0], rt[4:0], imediato[15:0]  latched IR fields
//   pc[31:0], pc_upper[3:0]
//   ir_valid, busy, align_err, fetch_err           status pulses/levels
//   state_dbg[1:0]                                 current FSM state
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pc_write,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] reg_target,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [15:0] imediato,
    output logic [31:0] pc,
    output logic [3:0]  pc_upper,
    output logic        ir_valid,
    output logic        busy,
    output logic        align_err,
    output logic        fetch_err,
    output logic [1:0]  state_dbg
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_plus4;
    logic [31:0]  pc_sel;
    logic         pc_load;
    logic         fetch_done;
    logic         timeout_hit;
    logic         align_q;

    assign pc_plus4 = pc_q + 32'd4;  // wraps modulo 2^32

    always_comb begin
        pc_sel = pc_plus4;
        case (pc_src)
            PC_SRC_BRANCH: pc_sel = branch_target;
            PC_SRC_JUMP:   pc_sel = jump_target;
            PC_SRC_REG:    pc_sel = reg_target;
            default:       pc_sel = pc_plus4;
        endcase
    end

    // pc_write wins over start in IDLE and is ignored while busy.
    assign pc_load    = (state_q == ST_IDLE) && pc_write;
    assign fetch_done = (state_q == ST_REQ) && mem_ready;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             fetch_err_q;

    // The cycle carrying the TIMEOUT_CYC-th consecutive wait aborts.
    assign timeout_hit = (state_q == ST_REQ) && !mem_ready &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt    <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= timeout_hit;
            if ((state_q == ST_REQ) && !mem_ready && !timeout_hit) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_d  = state_q;
        mem_rd   = 1'b0;
        ir_valid = 1'b0;
        busy     = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start && !pc_write) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                ir_valid = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC register: loads force word alignment; misalignment is flagged one
    // cycle later through align_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            align_q <= 1'b0;
        end else begin
            align_q <= pc_load && (pc_sel[1:0] != 2'b00);
            if (pc_load) begin
                pc_q <= {pc_sel[31:2], 2'b00};
            end else if (fetch_done) begin
                pc_q <= pc_plus4;
            end
        end
    end

    ir_reg u_ir_reg (
        .clk      (clk),
        .clr_n    (reset),
        .load     (fetch_done),
        .d        (mem_rdata),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .imediato (imediato)
    );

    assign mem_addr  = pc_q;
    assign pc        = pc_q;
    assign pc_upper  = pc_q[31:28];
    assign align_err = align_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pc_write = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] branch_target = '0;
  logic [31:0] jump_target = '0;
  logic [31:0] reg_target = '0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imediato;
  logic [31:0] pc;
  logic [3:0]  pc_upper;
  logic        ir_valid;
  logic        busy;
  logic        align_err;
  logic        fetch_err;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .start(start), .pc_write(pc_write),
    .pc_src(pc_src), .branch_target(branch_target), .jump_target(jump_target),
    .reg_target(reg_target), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .opcode(opcode), .rs(rs),
    .rt(rt), .imediato(imediato), .pc(pc), .pc_upper(pc_upper),
    .ir_valid(ir_valid), .busy(busy), .align_err(align_err),
    .fetch_err(fetch_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_fetch(input string tag, input logic [31:0] data, input int waits,
                          input logic [31:0] exp_addr, input logic [31:0] exp_pc);
    logic [31:0] d;
    d = data;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_req_rd"}, mem_rd, 1);
    check({tag, "_req_addr"}, mem_addr, exp_addr);
    for (int i = 0; i < waits; i++) begin
      tick();
      check({tag, "_wait_rd"}, mem_rd, 1);
      check({tag, "_wait_addr"}, mem_addr, exp_addr);
    end
    mem_ready = 1'b1;
    mem_rdata = d;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    // start cycle + waits + ready cycle puts DONE at cycle waits+3
    check({tag, "_ir_valid"}, ir_valid, 1);
    check({tag, "_done_rd"}, mem_rd, 0);
    check({tag, "_opcode"}, opcode, d[31:26]);
    check({tag, "_rs"}, rs, d[25:21]);
    check({tag, "_rt"}, rt, d[20:16]);
    check({tag, "_imm"}, imediato, d[15:0]);
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_pc_upper"}, pc_upper, exp_pc[31:28]);
    tick();
    check({tag, "_ir_valid_drop"}, ir_valid, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_ir_hold"}, imediato, d[15:0]);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start;
    logic [1:0]  src;
    logic [31:0] branch;
    logic [31:0] jump;
    logic [31:0] regt;
    logic [31:0] exp_pc;
    logic        exp_align;
  } load_vec_t;

  load_vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b0, PC_SRC_JUMP,   32'h0, 32'hA000_0040, 32'h0, 32'hA000_0040, 1'b0};
    vecs[1] = '{1'b0, PC_SRC_BRANCH, 32'h0000_0102, 32'h0, 32'h0, 32'h0000_0100, 1'b1};
    vecs[2] = '{1'b0, PC_SRC_SEQ,    32'h0, 32'h0, 32'h0, 32'h0000_0104, 1'b0};
    vecs[3] = '{1'b0, PC_SRC_REG,    32'h0, 32'h0, 32'h1234_5677, 32'h1234_5674, 1'b1};
    vecs[4] = '{1'b0, PC_SRC_SEQ,    32'h0, 32'h0, 32'h0, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b0, PC_SRC_REG,    32'h0, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[6] = '{1'b0, PC_SRC_SEQ,    32'h0, 32'h0, 32'h0, 32'h0000_0000, 1'b0};
    vecs[7] = '{1'b1, PC_SRC_JUMP,   32'h0, 32'h8000_0003, 32'h0, 32'h8000_0000, 1'b1};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_align", align_err, 0);
    check("rst_fetch_err", fetch_err, 0);
    check("rst_opcode", opcode, 0);
    check("rst_state", state_dbg, 2'(ST_IDLE));
    reset = 1'b1;
    tick();

    // ---- scenario 1: fetch with two wait cycles ----
    do_fetch("s1", 32'h0800_0010, 2, 32'h0, 32'h0000_0004);

    // ---- table: PC loads in IDLE ----
    for (int i = 0; i < 8; i++) begin
      start = vecs[i].start;
      pc_write = 1'b1;
      pc_src = vecs[i].src;
      branch_target = vecs[i].branch;
      jump_target = vecs[i].jump;
      reg_target = vecs[i].regt;
      tick();
      pc_write = 1'b0;
      start = 1'b0;
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_pc_upper", i), pc_upper, vecs[i].exp_pc[31:28]);
      check($sformatf("vec%0d_align", i), align_err, vecs[i].exp_align);
      check($sformatf("vec%0d_mem_rd", i), mem_rd, 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
      tick();
      check($sformatf("vec%0d_align_drop", i), align_err, 0);
    end

    // ---- scenario 2: jump load then fetch from it ----
    pc_write = 1'b1;
    pc_src = PC_SRC_JUMP;
    jump_target = 32'hA000_0040;
    tick();
    pc_write = 1'b0;
    check("s2_pc", pc, 32'hA000_0040);
    check("s2_pc_upper", pc_upper, 4'hA);
    do_fetch("s2", 32'h8C22_0005, 0, 32'hA000_0040, 32'hA000_0044);

    // ---- scenario 4: wrap at top of address space ----
    pc_write = 1'b1;
    pc_src = PC_SRC_REG;
    reg_target = 32'hFFFF_FFFC;
    tick();
    pc_write = 1'b0;
    do_fetch("s4", 32'h2001_FFFF, 1, 32'hFFFF_FFFC, 32'h0);

    // ---- start and pc_write ignored while busy, start not queued ----
    start = 1'b1;
    tick();
    check("busy_req_rd", mem_rd, 1);
    pc_write = 1'b1;
    pc_src = PC_SRC_JUMP;
    jump_target = 32'h5555_0000;
    tick();
    check("busy_pcw_ignored", pc, 32'h0);
    check("busy_still_req", mem_rd, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_1111;
    tick();
    mem_ready = 1'b0;
    pc_write = 1'b0;
    check("busy_done_valid", ir_valid, 1);
    check("busy_done_pc", pc, 32'h4);
    tick();
    start = 1'b0;
    check("busy_back_idle", busy, 0);
    tick();
    check("busy_start_not_queued", busy, 0);
    check("busy_no_rd", mem_rd, 0);

    // ---- scenario 5: reset during REQ ----
    start = 1'b1;
    tick();
    start = 1'b0;
    check("s5_req_rd", mem_rd, 1);
    #2 reset = 1'b0;
    #1;
    check("s5_rd_cleared", mem_rd, 0);
    check("s5_pc_reset", pc, 32'h0);
    check("s5_busy", busy, 0);
    check("s5_ir_cleared", imediato, 0);
    check("s5_state", state_dbg, 2'(ST_IDLE));
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("s5_late_ready_no_valid", ir_valid, 0);
      check("s5_late_ready_idle", busy, 0);
    end
    mem_ready = 1'b0;
    check("s5_ir_still_clear", opcode, 0);
    do_fetch("s5_refetch", 32'h0C00_0003, 0, 32'h0, 32'h4);

    // ---- scenario 6: mem_ready held low ----
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) begin
      tick();
      check("s6_waiting_busy", busy, 1);
      check("s6_no_err_yet", fetch_err, 0);
    end
    tick();
    check("s6_fetch_err", fetch_err, 1);
    check("s6_idle", state_dbg, 2'(ST_IDLE));
    check("s6_pc_kept", pc, 32'h4);
    check("s6_ir_kept", imediato, 16'h0003);
    tick();
    check("s6_err_drop", fetch_err, 0);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      check("s6_wait_forever_busy", busy, 1);
      check("s6_no_fetch_err", fetch_err, 0);
    end
    check("s6_rd_held", mem_rd, 1);
    mem_ready = 1'b1;
    mem_rdata = 32'h0000_0042;
    tick();
    mem_ready = 1'b0;
    check("s6_late_done", ir_valid, 1);
    check("s6_pc_adv", pc, 32'h8);
    tick();
`endif

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter TIMEOUT_CYC, default 15, is the maximum number of wait cycles for mem_ready before abort; only used when FETCH_TIMEOUT_EN is defined.
REQ-003 clk  in  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  is the reset: asynchronous, active-low.
REQ-005 start  in  1  is the fetch request from the control unit.
REQ-006 pc_write  in  1  is the PC load strobe.
REQ-007 pc_src  in  2  selects the next PC: 00 pc+4, 01 branch_target, 10 jump_target, 11 reg_target.
REQ-008 branch_target, jump_target, reg_target  in  32  are the candidate next-PC values; jump_target comes from the jump-address stage.
REQ-009 mem_rd  out  1  is the instruction read request; mem_addr  out  32  is the read address.
REQ-010 mem_ready  in  1  signals that mem_rdata  in  32  holds valid read data.
REQ-011 opcode  out  6, rs  out  5, rt  out  5 and imediato  out  16 are the latched IR fields: IR[31:26], IR[25:21], IR[20:16] and IR[15:0].
REQ-012 pc  out  32 is the current PC; pc_upper  out  4 is pc[31:28], fed to the jump-address stage.
REQ-013 ir_valid  out  1 is a one-cycle pulse when a new IR is latched; busy  out  1 is high in any state other than IDLE.
REQ-014 align_err  out  1 is a one-cycle pulse on a misaligned PC load; fetch_err  out  1 is a one-cycle pulse on timeout.

Function
REQ-015 The FSM states are IDLE, REQ and DONE.
REQ-016 Transitions:
- IDLE->REQ on start=1 with pc_write=0.
- REQ->DONE on mem_ready=1.
- DONE->IDLE unconditionally.
REQ-017 In REQ: mem_rd=1 and mem_addr=pc, held stable until mem_ready; mem_rd=0 in every other state.
REQ-018 On the REQ cycle in which mem_ready=1:
- IR <= mem_rdata;
- pc <= pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-019 ir_valid=1 in DONE only; the IR fields hold their value until the next successful fetch.
REQ-020 Fetch latency: a minimum of 3 cycles from start to ir_valid (start cycle, REQ with mem_ready=1, DONE).
REQ-021 pc_write is honoured only in IDLE: pc <= selected source with bits [1:0] forced to 00; pc_write is ignored while busy.
REQ-022 If the selected source has bits [1:0] nonzero when loaded, align_err pulses in the next cycle.
REQ-023 If pc_write and start are both 1 in IDLE, the PC load takes effect, start is dropped, and the FSM stays in IDLE.
REQ-024 A start while busy is ignored; it is not queued.
REQ-025 pc_src=00 under pc_write loads pc+4 without a fetch.

Reset
REQ-026 Asserting reset, at any time including mid-fetch, SHALL immediately set:
- state to IDLE;
- pc to RESET_PC;
- IR to 0;
- mem_rd, ir_valid, busy, align_err and fetch_err to 0;
- the wait counter to 0.
REQ-027 After reset deasserts, the first start fetches from RESET_PC; any memory response arriving for an aborted request is ignored.

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined:
- a wait counter increments each REQ cycle with mem_ready=0;
- on reaching TIMEOUT_CYC, the FSM returns to IDLE, fetch_err pulses, and pc and IR are unchanged.
REQ-029 Macro FETCH_TIMEOUT_EN undefined: no counter and no timeout; REQ waits indefinitely; fetch_err is tied to 0.

Structure
REQ-030 A shared package holds:
- the pc_src encodings;
- the FSM state enum;
- the RESET_PC default;
- the TIMEOUT_CYC default;
- the IR field bit positions.
REQ-031 One sub-module, ir_reg, holds the 32-bit IR with load enable and asynchronous active-low clear, and splits it into opcode, rs, rt and imediato.

Verification
REQ-032 Scenario 1: reset, then start; memory returns 32'h0800_0010 after 2 wait cycles -> ir_valid on cycle 5 after start; opcode=6'h02, imediato=16'h0010, pc=32'h4, pc_upper=4'h0.
REQ-033 Scenario 2: in IDLE, pc_write=1, pc_src=10, jump_target=32'hA000_0040 -> pc=32'hA000_0040 and pc_upper=4'hA; the next fetch drives mem_addr=32'hA000_0040.
REQ-034 Scenario 3: pc_write with pc_src=01 and branch_target=32'h0000_0102 -> pc=32'h0000_0100, with align_err pulsing for 1 cycle.
REQ-035 Scenario 4: pc=32'hFFFF_FFFC, then a fetch completes -> pc=32'h0; start and pc_write asserted together -> PC loaded, no mem_rd.
REQ-036 Scenario 5: reset asserted during REQ -> mem_rd=0 in the same cycle and pc=RESET_PC; a late mem_ready produces no ir_valid.
REQ-037 Scenario 6, with FETCH_TIMEOUT_EN defined: mem_ready is held low -> fetch_err pulses after 15 wait cycles, state returns to IDLE, and pc is unchanged.
